// File: rtl/hit_collect.sv
// hit_collect: drains the per-triangle hit flags coming out of hit_bool.
// It groups NUM_TRIS consecutive flags into one ray and writes one record
// per ray into an internal first-word fall-through FIFO. Each record holds
// hit/miss and the lowest hitting triangle index.
//
// Optional feature macro: HIT_COLLECT_COUNT_EN
//   When it is defined, each record is prefixed with the number of hitting
//   triangles in the ray.
//
// Ports:
//   clock           single clock, posedge
//   reset           asynchronous, active-high
//   hit_fifo_empty  upstream hit FIFO empty flag
//   hit_fifo_dout   upstream hit flag (fall-through, valid while !empty)
//   hit_fifo_rd_en  pop strobe to the upstream FIFO (combinational)
//   out_fifo_rd_en  downstream pop of ray records (ignored while empty)
//   out_fifo_dout   head record: {[hit_count,] hit, tri_idx}; 0 while empty
//   out_fifo_empty  no ray record available
module hit_collect #(
    parameter int unsigned NUM_TRIS       = 16,
    parameter int unsigned TRI_BITS       = 4,
    parameter int unsigned OUT_FIFO_DEPTH = 16,
`ifdef HIT_COLLECT_COUNT_EN
    localparam int unsigned REC_W         = 2 * TRI_BITS + 2
`else
    localparam int unsigned REC_W         = TRI_BITS + 1
`endif
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             hit_fifo_empty,
    input  logic             hit_fifo_dout,
    output logic             hit_fifo_rd_en,
    input  logic             out_fifo_rd_en,
    output logic [REC_W-1:0] out_fifo_dout,
    output logic             out_fifo_empty
);

    localparam int unsigned PTR_W = (OUT_FIFO_DEPTH > 1) ? $clog2(OUT_FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(OUT_FIFO_DEPTH + 1);
    localparam logic [TRI_BITS-1:0] LAST_TRI = TRI_BITS'(NUM_TRIS - 1);

    typedef enum logic {S_READ, S_WRITE} state_t;

    state_t              state;
    logic [TRI_BITS-1:0] tri_cnt;
    logic                found;
    logic [TRI_BITS-1:0] best_idx;
`ifdef HIT_COLLECT_COUNT_EN
    logic [TRI_BITS:0]   hit_count;
`endif

    logic                out_full;
    logic                wr_en;
    logic                rd_ok;
    logic [REC_W-1:0]    din;

    // Output FIFO storage and bookkeeping
    logic [REC_W-1:0]    mem [OUT_FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OUT_FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Upstream is only popped in S_READ; never while it is empty or in reset.
    assign hit_fifo_rd_en = !reset && (state == S_READ) && !hit_fifo_empty;

    assign out_full       = (count == CNT_W'(OUT_FIFO_DEPTH));
    assign out_fifo_empty = (count == '0);
    assign wr_en          = (state == S_WRITE) && !out_full;
    assign rd_ok          = out_fifo_rd_en && !out_fifo_empty;
    assign out_fifo_dout  = out_fifo_empty ? '0 : mem[rd_ptr];

`ifdef HIT_COLLECT_COUNT_EN
    assign din = {hit_count, found, found ? best_idx : '0};
`else
    assign din = {found, found ? best_idx : '0};
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= S_READ;
            tri_cnt  <= '0;
            found    <= 1'b0;
            best_idx <= '0;
`ifdef HIT_COLLECT_COUNT_EN
            hit_count <= '0;
`endif
        end else begin
            unique case (state)
                S_READ: begin
                    if (!hit_fifo_empty) begin
                        // First hit in the ray fixes the lowest index.
                        if (hit_fifo_dout && !found) begin
                            found    <= 1'b1;
                            best_idx <= tri_cnt;
                        end
`ifdef HIT_COLLECT_COUNT_EN
                        if (hit_fifo_dout) begin
                            hit_count <= hit_count + 1'b1;
                        end
`endif
                        if (tri_cnt == LAST_TRI) begin
                            tri_cnt <= '0;
                            state   <= S_WRITE;
                        end else begin
                            tri_cnt <= tri_cnt + 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    // Hold the record here while the output FIFO is full.
                    if (!out_full) begin
                        found    <= 1'b0;
                        best_idx <= '0;
`ifdef HIT_COLLECT_COUNT_EN
                        hit_count <= '0;
`endif
                        state    <= S_READ;
                    end
                end
                default: state <= S_READ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rd_ok) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            unique case ({wr_en, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_hit_collect.sv
module tb_hit_collect;

    localparam int unsigned NUM_TRIS = 4;
    localparam int unsigned TRI_BITS = 4;
    localparam int unsigned DEPTH    = 16;
`ifdef HIT_COLLECT_COUNT_EN
    localparam int unsigned REC_W = 2 * TRI_BITS + 2;
`else
    localparam int unsigned REC_W = TRI_BITS + 1;
`endif

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             hit_fifo_empty = 1'b1;
    logic             hit_fifo_dout = 1'b0;
    logic             hit_fifo_rd_en;
    logic             out_fifo_rd_en = 1'b0;
    logic [REC_W-1:0] out_fifo_dout;
    logic             out_fifo_empty;

    // Second instance for the single-triangle configuration
    logic             e1 = 1'b1;
    logic             d1 = 1'b0;
    logic             rd_en1;
    logic             orden1 = 1'b0;
    logic [REC_W-1:0] dout1;
    logic             oempty1;

    always #5 clock = ~clock;

    hit_collect #(.NUM_TRIS(NUM_TRIS), .TRI_BITS(TRI_BITS), .OUT_FIFO_DEPTH(DEPTH)) dut (
        .clock          (clock),
        .reset          (reset),
        .hit_fifo_empty (hit_fifo_empty),
        .hit_fifo_dout  (hit_fifo_dout),
        .hit_fifo_rd_en (hit_fifo_rd_en),
        .out_fifo_rd_en (out_fifo_rd_en),
        .out_fifo_dout  (out_fifo_dout),
        .out_fifo_empty (out_fifo_empty)
    );

    hit_collect #(.NUM_TRIS(1), .TRI_BITS(TRI_BITS), .OUT_FIFO_DEPTH(DEPTH)) dut1 (
        .clock          (clock),
        .reset          (reset),
        .hit_fifo_empty (e1),
        .hit_fifo_dout  (d1),
        .hit_fifo_rd_en (rd_en1),
        .out_fifo_rd_en (orden1),
        .out_fifo_dout  (dout1),
        .out_fifo_empty (oempty1)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int pops     = 0;

    bit               src_q[$];      // upstream flags not yet popped
    bit               ray_flags[$];  // flags popped for the ray in progress
    logic [REC_W-1:0] exp_q[$];      // records the DUT owes, in order

    logic             last_rd_en;
    logic             last_empty;
    logic [REC_W-1:0] last_dout;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [REC_W-1:0] mk(input bit hit, input int idx, input int cnt);
`ifdef HIT_COLLECT_COUNT_EN
        return {(TRI_BITS + 1)'(cnt), hit, TRI_BITS'(idx)};
`else
        if (cnt < 0) return '0;
        return {hit, TRI_BITS'(idx)};
`endif
    endfunction

    // Reference: a ray record is "any flag set", the first set position and the popcount.
    task automatic take(input bit f);
        int first;
        int ones;
        ray_flags.push_back(f);
        if (ray_flags.size() == NUM_TRIS) begin
            first = -1;
            ones  = 0;
            foreach (ray_flags[i]) begin
                if (ray_flags[i]) begin
                    ones++;
                    if (first < 0) first = i;
                end
            end
            exp_q.push_back(mk(first >= 0, (first >= 0) ? first : 0, ones));
            ray_flags.delete();
        end
    endtask

    // One clock: drive at negedge, sample #1 later, the DUT acts on the next posedge.
    task automatic cycle(input bit gap, input bit rd);
        bit f;
        @(negedge clock);
        hit_fifo_empty = gap || (src_q.size() == 0);
        hit_fifo_dout  = hit_fifo_empty ? 1'($urandom) : src_q[0];
        out_fifo_rd_en = rd;
        #1;
        last_rd_en = hit_fifo_rd_en;
        last_empty = out_fifo_empty;
        last_dout  = out_fifo_dout;
        check("rd_en_while_empty", 32'(hit_fifo_rd_en & hit_fifo_empty), 0);
        if (!out_fifo_empty) begin
            if (exp_q.size() == 0) begin
                check("spurious_record", 32'(out_fifo_dout), 32'hFFFF_FFFF);
            end else begin
                check("record", 32'(out_fifo_dout), 32'(exp_q[0]));
                if (rd) void'(exp_q.pop_front());
            end
        end
        if (hit_fifo_rd_en && !hit_fifo_empty) begin
            f = src_q.pop_front();
            pops++;
            take(f);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset          = 1'b1;
        hit_fifo_empty = 1'b0;
        hit_fifo_dout  = 1'b1;
        out_fifo_rd_en = 1'b0;
        src_q.delete();
        ray_flags.delete();
        exp_q.delete();
        #1;
        check("reset_rd_en", 32'(hit_fifo_rd_en), 0);
        check("reset_out_empty", 32'(out_fifo_empty), 1);
        check("reset_out_dout", 32'(out_fifo_dout), 0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset          = 1'b0;
        hit_fifo_empty = 1'b1;
        pops           = 0;
    endtask

    task automatic push_flags(input logic [31:0] bits, input int n);
        for (int i = 0; i < n; i++) src_q.push_back(bits[i]);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((src_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
            cycle(1'b0, 1'b1);
            n++;
        end
        check("drain_left", 32'(src_q.size() + exp_q.size()), 0);
    endtask

    initial begin
        bit f6[3];
        int guard;

        do_reset();

        // 1: flags 0,0,1,0 -> {1,2}, written the cycle after the 4th pop
        push_flags(32'b0100, 4);
        for (int c = 1; c <= 6; c++) begin
            cycle(1'b0, c == 6);
            if (c == 5) check("t1_not_early", 32'(last_empty), 1);
        end
        check("t1_visible", 32'(last_empty), 0);
        check("t1_rec", 32'(last_dout), 32'(mk(1, 2, 1)));
        check("t1_pops", pops, 4);
        cycle(1'b0, 1'b0);
        check("t1_one_rec", 32'(last_empty), 1);

        // 2: all-miss ray then 1,1,0,1
        pops = 0;
        push_flags(32'b1011_0000, 8);
        repeat (12) cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1);
        check("t2_rec0", 32'(last_dout), 32'(mk(0, 0, 0)));
        cycle(1'b0, 1'b1);
        check("t2_rec1", 32'(last_dout), 32'(mk(1, 0, 3)));
        cycle(1'b0, 1'b0);
        check("t2_empty", 32'(last_empty), 1);

        // 3: upstream empty every other cycle
        pops = 0;
        push_flags(32'b0001, 4);
        for (int i = 0; i < 12; i++) cycle(i % 2 == 0, 1'b0);
        check("t3_pops", pops, 4);
        check("t3_rec", 32'(last_dout), 32'(mk(1, 0, 1)));
        cycle(1'b0, 1'b1);

        // 4: backpressure with DEPTH+1 rays and one more ray waiting
        pops = 0;
        for (int r = 0; r < DEPTH + 2; r++) push_flags($urandom, NUM_TRIS);
        repeat (110) cycle(1'b0, 1'b0);
        check("t4_pops_stalled", pops, (DEPTH + 1) * NUM_TRIS);
        check("t4_rd_en_stalled", 32'(last_rd_en), 0);
        check("t4_out_nonempty", 32'(last_empty), 0);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        check("t4_still_bubble", 32'(last_rd_en), 0);
        cycle(1'b0, 1'b0);
        check("t4_resume", 32'(last_rd_en), 1);
        drain(400);

        // 5: reset mid-ray with a completed record still queued
        push_flags(32'b0001, 4);
        repeat (6) cycle(1'b0, 1'b0);
        check("t5_pre_rec", 32'(last_empty), 0);
        push_flags(32'b11, 2);
        repeat (2) cycle(1'b0, 1'b0);
        do_reset();
        push_flags(32'b1000, 4);
        repeat (6) cycle(1'b0, 1'b0);
        check("t5_rec", 32'(last_dout), 32'(mk(1, 3, 1)));
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        check("t5_single", 32'(last_empty), 1);

        // Randomized rays, upstream gaps and downstream pops
        for (int r = 0; r < 40; r++) begin
            if ($urandom_range(3) == 0) push_flags(0, NUM_TRIS);
            else push_flags($urandom & $urandom, NUM_TRIS);
        end
        for (int i = 0; i < 400; i++) cycle($urandom_range(9) < 3, $urandom_range(1) == 1);
        drain(600);

        // 6: NUM_TRIS=1, flags 1,0,1
        f6[0] = 1'b1;
        f6[1] = 1'b0;
        f6[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            e1 = 1'b0;
            d1 = f6[i];
            #1;
            guard = 0;
            while (!rd_en1 && guard < 10) begin
                @(negedge clock);
                #1;
                guard++;
            end
            check("t6_pop", 32'(rd_en1), 1);
        end
        @(negedge clock);
        e1 = 1'b1;
        repeat (3) @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            #1;
            check("t6_nonempty", 32'(oempty1), 0);
            check("t6_rec", 32'(dout1), 32'(mk(f6[i], 0, 32'(f6[i]))));
            orden1 = 1'b1;
            @(posedge clock);
            #1;
            orden1 = 1'b0;
        end
        @(negedge clock);
        check("t6_empty", 32'(oempty1), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
